// File: rtl/i2c_master_phy_if.sv
// Command and pad bundle between the I2C command sequencer and the bit-level PHY.
interface i2c_master_phy_if;
    logic       i2c_en;
    logic       start;
    logic       stop;
    logic [7:0] tx_data;
    logic       ready;
    logic       tx_done;
    logic       nack;
    logic       bus_busy;
    logic       scl;
    logic       sda_oe;
    logic       sda_in;

    modport master (output i2c_en, start, stop, tx_data, sda_in,
                    input  ready, tx_done, nack, bus_busy, scl, sda_oe);
    modport slave  (input  i2c_en, start, stop, tx_data, sda_in,
                    output ready, tx_done, nack, bus_busy, scl, sda_oe);
endinterface

// File: rtl/i2c_master_phy.sv
// Write-only single-master I2C bit engine: START/RSTART/byte/ACK/STOP on a quarter-period timebase.
module i2c_master_phy #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int I2C_FREQ_HZ = 100_000
) (
    input logic              clk,
    input logic              reset,
    i2c_master_phy_if.slave  bus
);
    localparam int QTR = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
    localparam int QW  = (QTR > 2) ? $clog2(QTR) : 1;

    typedef enum logic [2:0] {IDLE, START, RSTART, DATA, ACK, HOLD, STOP} state_t;

    state_t        state, state_n;
    logic [QW-1:0] qcnt;
    logic [1:0]    phase;
    logic [2:0]    bcnt;
    logic [7:0]    shreg;
    logic [7:0]    cur_byte;
    logic          load_d;
    logic [1:0]    sda_sync;
    logic          tx_done_q, nack_q;
    logic          rdy, busy, scl_c, oe_c;
    logic          accept, qwrap;

    // Commands other than START are dropped while idle, so they never count as an accept.
    assign accept = bus.i2c_en & rdy & (bus.start | (state == HOLD));
    assign qwrap  = (qcnt == QW'(QTR - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (accept) state_n = START;
            START:  if (qwrap && phase == 2'd1) state_n = DATA;
            RSTART: if (qwrap && phase == 2'd3) state_n = DATA;
            DATA:   if (qwrap && phase == 2'd3 && bcnt == 3'd7) state_n = ACK;
            ACK:    if (qwrap && phase == 2'd3) state_n = HOLD;
            HOLD:   if (accept) state_n = bus.stop ? STOP : (bus.start ? RSTART : DATA);
            STOP:   if (qwrap && phase == 2'd2) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            qcnt      <= '0;
            phase     <= 2'd0;
            bcnt      <= 3'd0;
            shreg     <= 8'h00;
            load_d    <= 1'b0;
            sda_sync  <= 2'b11;
            tx_done_q <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            load_d    <= accept;
            sda_sync  <= {sda_sync[0], bus.sda_in};
            tx_done_q <= (state == ACK) && (phase == 2'd3) && qwrap;
            if (load_d) shreg <= bus.tx_data;
            if ((state == ACK) && (phase == 2'd2) && qwrap) nack_q <= sda_sync[1];
            if (state == IDLE || state == HOLD) begin
                qcnt  <= '0;
                phase <= 2'd0;
                bcnt  <= 3'd0;
            end else if (qwrap) begin
                qcnt  <= '0;
                phase <= (state_n != state) ? 2'd0 : phase + 2'd1;
                if (state == DATA && phase == 2'd3) bcnt <= bcnt + 3'd1;
            end else begin
                qcnt <= qcnt + 1'b1;
            end
        end
    end

    // The byte register loads one cycle late, so the first bit of a byte issued from
    // HOLD is taken straight from the command bus during that cycle.
    assign cur_byte = load_d ? bus.tx_data : shreg;

    always_comb begin
        rdy   = 1'b0;
        busy  = 1'b1;
        scl_c = 1'b1;
        oe_c  = 1'b0;
        case (state)
            IDLE:   begin rdy = 1'b1; busy = 1'b0; end
            START:  begin scl_c = (phase == 2'd0); oe_c = 1'b1; end
            RSTART: begin scl_c = (phase == 2'd1) || (phase == 2'd2); oe_c = phase[1]; end
            DATA:   begin scl_c = (phase == 2'd1) || (phase == 2'd2); oe_c = ~cur_byte[~bcnt]; end
            ACK:    begin scl_c = (phase == 2'd1) || (phase == 2'd2); oe_c = 1'b0; end
            HOLD:   begin rdy = 1'b1; scl_c = 1'b0; end
            STOP:   begin scl_c = (phase != 2'd0); oe_c = (phase != 2'd2); end
            default: begin rdy = 1'b1; busy = 1'b0; end
        endcase
    end

    assign bus.ready    = rdy;
    assign bus.bus_busy = busy;
    assign bus.scl      = scl_c;
    assign bus.sda_oe   = oe_c;
    assign bus.tx_done  = tx_done_q;
    assign bus.nack     = nack_q;
endmodule

// File: tb/tb_i2c_master_phy.sv
// Directed bench for i2c_master_phy at QTR=25: bus waveform decode, latency and boundary cases.
module tb_i2c_master_phy;
    localparam logic [7:0] FRAME [6] = '{8'hAA, 8'h40, 8'h7F, 8'h05, 8'h02, 8'h01};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0, fails = 0;

    i2c_master_phy_if bus();

    i2c_master_phy #(.CLK_FREQ_HZ(100_000_000), .I2C_FREQ_HZ(1_000_000)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: SDA value at each SCL rise, START/STOP conditions, tx_done pulses.
    logic pscl = 1'b1, poe = 1'b0;
    int   start_cnt = 0, stop_cnt = 0, done_cnt = 0, last_done = -1;
    logic bits[$];
    always @(negedge clk) begin
        if (bus.tx_done) begin done_cnt <= done_cnt + 1; last_done <= cyc; end
        if (!pscl && bus.scl) bits.push_back(~bus.sda_oe);
        if (pscl && bus.scl && !poe && bus.sda_oe) start_cnt <= start_cnt + 1;
        if (pscl && bus.scl && poe && !bus.sda_oe) stop_cnt <= stop_cnt + 1;
        pscl <= bus.scl;
        poe  <= bus.sda_oe;
    end

    task automatic tick;
        @(negedge clk); #1;
    endtask

    task automatic send(input logic st, input logic sp, input logic [7:0] d,
                        output int acc, output logic r1);
        bus.start = st; bus.stop = sp; bus.tx_data = d; bus.i2c_en = 1'b1;
        acc = cyc;
        tick;
        r1 = bus.ready;
        bus.i2c_en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        tick;
        bus.tx_data = ~d;
    endtask

    task automatic wait_done(input int n, output int dc);
        dc = -1;
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt >= n) begin dc = last_done; break; end
            tick;
        end
    endtask

    function automatic logic [7:0] get_byte(input int off);
        logic [7:0] b;
        if (off + 7 >= bits.size()) return 8'hxx;
        b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], bits[off + i]};
        return b;
    endfunction

    task automatic test_reset;
        repeat (3) tick;
        checks++; if (bus.ready !== 1'b1)    begin fails++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
        checks++; if (bus.tx_done !== 1'b0)  begin fails++; $display("FAIL reset_tx_done got=%b exp=0", bus.tx_done); end
        checks++; if (bus.nack !== 1'b0)     begin fails++; $display("FAIL reset_nack got=%b exp=0", bus.nack); end
        checks++; if (bus.bus_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.bus_busy); end
        checks++; if (bus.scl !== 1'b1)      begin fails++; $display("FAIL reset_scl got=%b exp=1", bus.scl); end
        checks++; if (bus.sda_oe !== 1'b0)   begin fails++; $display("FAIL reset_sda_oe got=%b exp=0", bus.sda_oe); end
        reset = 1'b0;
        repeat (2) tick;
    endtask

    task automatic test_start_byte;
        int acc, dc, b0, s0; logic r1;
        b0 = bits.size(); s0 = start_cnt; bus.sda_in = 1'b0;
        send(1'b1, 1'b0, 8'hAA, acc, r1);
        checks++; if (r1 !== 1'b0) begin fails++; $display("FAIL start_ready_drop got=%b exp=0", r1); end
        wait_done(done_cnt + 1, dc);
        checks++; if (dc - acc !== 951) begin fails++; $display("FAIL start_latency got=%0d exp=951", dc - acc); end
        checks++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL start_ready_at_done got=%b exp=1", bus.ready); end
        checks++; if (bus.bus_busy !== 1'b1 || bus.scl !== 1'b0) begin fails++; $display("FAIL start_hold busy=%b scl=%b exp=1,0", bus.bus_busy, bus.scl); end
        checks++; if (start_cnt - s0 !== 1) begin fails++; $display("FAIL start_cond got=%0d exp=1", start_cnt - s0); end
        checks++; if (bits.size() - b0 !== 9) begin fails++; $display("FAIL start_scl_pulses got=%0d exp=9", bits.size() - b0); end
        checks++; if (get_byte(b0) !== 8'hAA) begin fails++; $display("FAIL start_byte got=%h exp=aa", get_byte(b0)); end
        checks++; if (bus.nack !== 1'b0) begin fails++; $display("FAIL start_nack got=%b exp=0", bus.nack); end
        tick;
        checks++; if (bus.tx_done !== 1'b0) begin fails++; $display("FAIL start_done_width got=%b exp=0", bus.tx_done); end
    endtask

    task automatic test_hold_byte;
        int acc, dc, b0, s0; logic r1;
        b0 = bits.size(); s0 = start_cnt; bus.sda_in = 1'b1;
        send(1'b0, 1'b0, 8'h3C, acc, r1);
        wait_done(done_cnt + 1, dc);
        checks++; if (dc - acc !== 901) begin fails++; $display("FAIL hold_latency got=%0d exp=901", dc - acc); end
        checks++; if (start_cnt - s0 !== 0) begin fails++; $display("FAIL hold_no_start got=%0d exp=0", start_cnt - s0); end
        checks++; if (bits.size() - b0 !== 9) begin fails++; $display("FAIL hold_scl_pulses got=%0d exp=9", bits.size() - b0); end
        checks++; if (get_byte(b0) !== 8'h3C) begin fails++; $display("FAIL hold_byte got=%h exp=3c", get_byte(b0)); end
        checks++; if (bus.nack !== 1'b1) begin fails++; $display("FAIL hold_nack got=%b exp=1", bus.nack); end
        tick;
    endtask

    task automatic test_stop;
        int acc, d0, p0; logic r1;
        d0 = done_cnt; p0 = stop_cnt;
        send(1'b0, 1'b1, 8'h00, acc, r1);
        repeat (73) tick;
        checks++; if (bus.bus_busy !== 1'b1) begin fails++; $display("FAIL stop_busy_75 got=%b exp=1", bus.bus_busy); end
        tick;
        checks++; if (bus.bus_busy !== 1'b0 || bus.ready !== 1'b1) begin fails++; $display("FAIL stop_idle_76 busy=%b ready=%b exp=0,1", bus.bus_busy, bus.ready); end
        checks++; if (bus.scl !== 1'b1 || bus.sda_oe !== 1'b0) begin fails++; $display("FAIL stop_lines scl=%b oe=%b exp=1,0", bus.scl, bus.sda_oe); end
        checks++; if (stop_cnt - p0 !== 1) begin fails++; $display("FAIL stop_cond got=%0d exp=1", stop_cnt - p0); end
        checks++; if (done_cnt - d0 !== 0) begin fails++; $display("FAIL stop_no_done got=%0d exp=0", done_cnt - d0); end
    endtask

    task automatic test_ignore_idle;
        int acc, s0; logic r1;
        s0 = start_cnt;
        send(1'b0, 1'b0, 8'hFF, acc, r1);
        repeat (10) tick;
        checks++; if (bus.bus_busy !== 1'b0 || bus.ready !== 1'b1 || bus.scl !== 1'b1 || bus.sda_oe !== 1'b0 || start_cnt != s0)
            begin fails++; $display("FAIL idle_ignore busy=%b ready=%b scl=%b oe=%b exp=0,1,1,0", bus.bus_busy, bus.ready, bus.scl, bus.sda_oe); end
    endtask

    task automatic test_start_stop_same;
        int acc, dc, s0, p0, d0; logic r1;
        bus.sda_in = 1'b0; s0 = start_cnt; p0 = stop_cnt; d0 = done_cnt;
        send(1'b1, 1'b0, 8'h55, acc, r1);
        wait_done(d0 + 1, dc);
        tick;
        send(1'b1, 1'b1, 8'h99, acc, r1);
        repeat (74) tick;
        checks++; if (bus.bus_busy !== 1'b0) begin fails++; $display("FAIL both_idle got=%b exp=0", bus.bus_busy); end
        checks++; if (stop_cnt - p0 !== 1 || start_cnt - s0 !== 1)
            begin fails++; $display("FAIL both_stop_wins stops=%0d starts=%0d exp=1,1", stop_cnt - p0, start_cnt - s0); end
        checks++; if (done_cnt - d0 !== 1) begin fails++; $display("FAIL both_done got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_rstart;
        int acc, dc, b0, s0; logic r1;
        bus.sda_in = 1'b0;
        send(1'b1, 1'b0, 8'hC3, acc, r1);
        wait_done(done_cnt + 1, dc);
        tick;
        b0 = bits.size(); s0 = start_cnt; bus.sda_in = 1'b1;
        send(1'b1, 1'b0, 8'hA5, acc, r1);
        wait_done(done_cnt + 1, dc);
        checks++; if (dc - acc !== 1001) begin fails++; $display("FAIL rstart_latency got=%0d exp=1001", dc - acc); end
        checks++; if (start_cnt - s0 !== 1) begin fails++; $display("FAIL rstart_cond got=%0d exp=1", start_cnt - s0); end
        checks++; if (bits.size() - b0 !== 10) begin fails++; $display("FAIL rstart_scl_pulses got=%0d exp=10", bits.size() - b0); end
        checks++; if (get_byte(b0 + 1) !== 8'hA5) begin fails++; $display("FAIL rstart_byte got=%h exp=a5", get_byte(b0 + 1)); end
        checks++; if (bus.nack !== 1'b1) begin fails++; $display("FAIL rstart_nack got=%b exp=1", bus.nack); end
        tick;
        send(1'b0, 1'b1, 8'h00, acc, r1);
        repeat (80) tick;
    endtask

    task automatic test_frame;
        int acc, dc, b0, d0, p0; logic r1;
        bus.sda_in = 1'b0; b0 = bits.size(); d0 = done_cnt; p0 = stop_cnt;
        for (int k = 0; k < 6; k++) begin
            send(k == 0, 1'b0, FRAME[k], acc, r1);
            wait_done(d0 + k + 1, dc);
            checks++; if (get_byte(b0 + 9 * k) !== FRAME[k])
                begin fails++; $display("FAIL frame_byte%0d got=%h exp=%h", k, get_byte(b0 + 9 * k), FRAME[k]); end
            tick;
        end
        send(1'b0, 1'b1, 8'h00, acc, r1);
        repeat (80) tick;
        checks++; if (done_cnt - d0 !== 6) begin fails++; $display("FAIL frame_done_cnt got=%0d exp=6", done_cnt - d0); end
        checks++; if (bus.bus_busy !== 1'b0 || bus.ready !== 1'b1 || stop_cnt - p0 !== 1)
            begin fails++; $display("FAIL frame_idle busy=%b ready=%b stops=%0d exp=0,1,1", bus.bus_busy, bus.ready, stop_cnt - p0); end
        checks++; if (bus.nack !== 1'b0) begin fails++; $display("FAIL frame_nack got=%b exp=0", bus.nack); end
    endtask

    task automatic test_reset_mid;
        int acc, dc, b0; logic r1;
        bus.sda_in = 1'b0; b0 = bits.size();
        send(1'b1, 1'b0, 8'hF0, acc, r1);
        for (int i = 0; i < 2000 && bits.size() - b0 < 5; i++) tick;
        checks++; if (bits.size() - b0 < 5) begin fails++; $display("FAIL midrst_reach_bit4 got=%0d exp>=5", bits.size() - b0); end
        reset = 1'b1;
        #1;
        checks++; if (bus.scl !== 1'b1 || bus.sda_oe !== 1'b0 || bus.ready !== 1'b1 || bus.bus_busy !== 1'b0)
            begin fails++; $display("FAIL midrst_outputs scl=%b oe=%b ready=%b busy=%b exp=1,0,1,0", bus.scl, bus.sda_oe, bus.ready, bus.bus_busy); end
        tick; reset = 1'b0; tick; tick;
        b0 = bits.size();
        send(1'b1, 1'b0, 8'h81, acc, r1);
        wait_done(done_cnt + 1, dc);
        checks++; if (dc - acc !== 951) begin fails++; $display("FAIL midrst_latency got=%0d exp=951", dc - acc); end
        checks++; if (get_byte(b0) !== 8'h81) begin fails++; $display("FAIL midrst_byte got=%h exp=81", get_byte(b0)); end
    endtask

    initial begin
        bus.i2c_en = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.tx_data = 8'h00; bus.sda_in = 1'b1;
        test_reset;
        test_start_byte;
        test_hold_byte;
        test_stop;
        test_ignore_idle;
        test_start_stop_same;
        test_rstart;
        test_frame;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
